hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
- Tracks destination-register state of the instructions in EX and MEM and decides, for the instruction leaving ID, the registered 2-bit operand-select codes that drive the EX-stage 3:1 operand muxes.
- Select encoding: 0 = ID/EX register-file value, 1 = EX/MEM ALU result, 2 = MEM/WB write-back data.
- Detects load-use hazards, asserts a one-cycle stall and inserts a bubble into EX.
- Keeps a saturating stall counter for performance debug.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- CNT_W, 32, stall-counter width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ID_VALID  in  1  ID holds a real instruction.
- ID_RS  in  REG_ADDR_W  source A specifier.
- ID_RT  in  REG_ADDR_W  source B specifier.
- ID_USE_RS  in  1  instruction reads RS.
- ID_USE_RT  in  1  instruction reads RT.
- ID_RD  in  REG_ADDR_W  destination specifier, already resolved.
- ID_REGWRITE  in  1  instruction writes ID_RD.
- ID_MEMREAD  in  1  instruction is a load.
- FLUSH  in  1  kill the ID instruction (taken branch/jump).
- STALL  out  1  combinational; freezes PC and IF/ID.
- FWD_A  out  2  registered select for EX operand A.
- FWD_B  out  2  registered select for EX operand B.
- EX_BUBBLE  out  1  registered; EX holds a bubble this cycle.
- STALL_CNT  out  CNT_W  stall cycles since reset.

Behaviour:
- Internal state:
  - EX entry: ex_valid, ex_rd, ex_regwrite, ex_memread.
  - MEM entry: mem_valid, mem_rd, mem_regwrite.
- Reset (async, immediate): all entries invalid; FWD_A = FWD_B = 0; EX_BUBBLE = 1; STALL_CNT = 0. STALL is 0 while RESET is high.
- Producer match, EX: ex_valid & ex_regwrite & ex_rd != 0 & ex_rd == src.
- Producer match, MEM: same test on the MEM entry.
- Register 0 never matches.
- Load-use hazard (combinational):
  - hz = ID_VALID & !FLUSH & ex_memread & EX match on (ID_USE_RS & ID_RS) or (ID_USE_RT & ID_RT).
  - STALL = hz.
- Select per operand, computed only when the operand is used (else 0):
  - EX match gives 1.
  - Otherwise MEM match gives 2.
  - Otherwise 0.
  - EX match has priority over MEM match (newest producer wins).
- Each rising edge, MEM entry <= EX entry (always advances).
- Each rising edge, EX entry:
  - If FLUSH, !ID_VALID, or hz: EX entry <= bubble (valid 0); FWD_A/FWD_B <= 0; EX_BUBBLE <= 1.
  - Otherwise: EX entry <= {1, ID_RD, ID_REGWRITE, ID_MEMREAD}; FWD_A/FWD_B <= computed selects; EX_BUBBLE <= 0.
- Stall resolution: after one stall cycle the load sits in MEM, so the re-presented ID instruction sees a MEM match and gets select 2. A load-use stall lasts exactly one cycle.
- FLUSH has priority over a stall: a flushed instruction never stalls and STALL = 0.
- Distance-3 dependencies (producer in WB while consumer is in ID) are not handled here; the register file is write-first.
- STALL_CNT increments by 1 on each edge where STALL = 1, saturating at all-ones.
- FWD codes are only ever 0, 1 or 2; value 3 is never produced.

Test Plan:
- Reset mid-run, with entries valid and STALL_CNT = 7 → immediately FWD_A = FWD_B = 0, EX_BUBBLE = 1, STALL_CNT = 0, STALL = 0.
- Back-to-back ALU ops: add r3 then sub r5,r3,r4 (rs = 3) → after the sub's edge, FWD_A = 1, FWD_B = 0, no stall.
- One independent op between producer (rd = 3) and consumer (rt = 3) → FWD_B = 2.
- Both EX and MEM write r7, consumer rs = 7 → FWD_A = 1 (newest wins).
- lw r2 then add r6,r2,r2 (both sources used) → STALL = 1 for exactly one cycle, EX_BUBBLE = 1. Next edge FWD_A = FWD_B = 2 and STALL_CNT = 1.
- lw r2 followed by a consumer of r2 with FLUSH = 1 → STALL = 0, bubble enters EX.
- Producer writes r0 → consumer of r0 gets select 0 and no stall, even for a load.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Forwarding and load-use hazard unit: tracks the EX/MEM destination registers and
// produces registered EX operand-mux selects, a one-cycle load-use stall and a stall counter.
module hazard_forward_unit #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ID_VALID,
    input  logic [REG_ADDR_W-1:0] ID_RS,
    input  logic [REG_ADDR_W-1:0] ID_RT,
    input  logic                  ID_USE_RS,
    input  logic                  ID_USE_RT,
    input  logic [REG_ADDR_W-1:0] ID_RD,
    input  logic                  ID_REGWRITE,
    input  logic                  ID_MEMREAD,
    input  logic                  FLUSH,
    output logic                  STALL,
    output logic [1:0]            FWD_A,
    output logic [1:0]            FWD_B,
    output logic                  EX_BUBBLE,
    output logic [CNT_W-1:0]      STALL_CNT
);

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_EX  = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;

    logic                  ex_valid;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_regwrite;
    logic                  ex_memread;
    logic                  mem_valid;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_regwrite;

    logic ex_wr;
    logic mem_wr;
    logic ex_match_rs;
    logic ex_match_rt;
    logic mem_match_rs;
    logic mem_match_rt;
    logic hz;
    logic [1:0] sel_a;
    logic [1:0] sel_b;

    // Producer matches; register 0 is hard-wired and never forwards.
    always_comb begin
        ex_wr        = ex_valid  & ex_regwrite  & (ex_rd  != '0);
        mem_wr       = mem_valid & mem_regwrite & (mem_rd != '0);
        ex_match_rs  = ex_wr  & (ex_rd  == ID_RS);
        ex_match_rt  = ex_wr  & (ex_rd  == ID_RT);
        mem_match_rs = mem_wr & (mem_rd == ID_RS);
        mem_match_rt = mem_wr & (mem_rd == ID_RT);
    end

    // Load-use hazard: a load in EX feeds a used source of the ID instruction.
    always_comb begin
        hz    = ID_VALID & ~FLUSH & ex_memread &
                ((ID_USE_RS & ex_match_rs) | (ID_USE_RT & ex_match_rt));
        STALL = hz;
    end

    // Newest producer (EX) wins over MEM.
    always_comb begin
        sel_a = SEL_RF;
        sel_b = SEL_RF;
        if (ID_USE_RS) begin
            if (ex_match_rs)       sel_a = SEL_EX;
            else if (mem_match_rs) sel_a = SEL_MEM;
        end
        if (ID_USE_RT) begin
            if (ex_match_rt)       sel_b = SEL_EX;
            else if (mem_match_rt) sel_b = SEL_MEM;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ex_valid     <= 1'b0;
            ex_rd        <= '0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            mem_valid    <= 1'b0;
            mem_rd       <= '0;
            mem_regwrite <= 1'b0;
            FWD_A        <= SEL_RF;
            FWD_B        <= SEL_RF;
            EX_BUBBLE    <= 1'b1;
            STALL_CNT    <= '0;
        end else begin
            mem_valid    <= ex_valid;
            mem_rd       <= ex_rd;
            mem_regwrite <= ex_regwrite;

            if (FLUSH || !ID_VALID || hz) begin
                ex_valid    <= 1'b0;
                ex_rd       <= '0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
                FWD_A       <= SEL_RF;
                FWD_B       <= SEL_RF;
                EX_BUBBLE   <= 1'b1;
            end else begin
                ex_valid    <= 1'b1;
                ex_rd       <= ID_RD;
                ex_regwrite <= ID_REGWRITE;
                ex_memread  <= ID_MEMREAD;
                FWD_A       <= sel_a;
                FWD_B       <= sel_b;
                EX_BUBBLE   <= 1'b0;
            end

            // Saturating performance counter.
            if (hz && (STALL_CNT != '1))
                STALL_CNT <= STALL_CNT + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: registered outputs are checked through an
// expected-value queue, STALL is checked combinationally before each edge.
module tb_hazard_forward_unit;

    logic        CLK;
    logic        RESET;
    logic        ID_VALID;
    logic [4:0]  ID_RS;
    logic [4:0]  ID_RT;
    logic        ID_USE_RS;
    logic        ID_USE_RT;
    logic [4:0]  ID_RD;
    logic        ID_REGWRITE;
    logic        ID_MEMREAD;
    logic        FLUSH;
    logic        STALL;
    logic [1:0]  FWD_A;
    logic [1:0]  FWD_B;
    logic        EX_BUBBLE;
    logic [31:0] STALL_CNT;

    typedef struct {
        string       tag;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        bub;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] model_cnt = 0;

    hazard_forward_unit #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ID_VALID   (ID_VALID),
        .ID_RS      (ID_RS),
        .ID_RT      (ID_RT),
        .ID_USE_RS  (ID_USE_RS),
        .ID_USE_RT  (ID_USE_RT),
        .ID_RD      (ID_RD),
        .ID_REGWRITE(ID_REGWRITE),
        .ID_MEMREAD (ID_MEMREAD),
        .FLUSH      (FLUSH),
        .STALL      (STALL),
        .FWD_A      (FWD_A),
        .FWD_B      (FWD_B),
        .EX_BUBBLE  (EX_BUBBLE),
        .STALL_CNT  (STALL_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one ID instruction at the falling edge, check STALL, then the registered outputs.
    task automatic step(input string tag, input logic v,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt,
                        input logic [4:0] rd, input logic rw, input logic mr, input logic fl,
                        input logic es, input logic [1:0] ea, input logic [1:0] eb,
                        input logic ebub);
        exp_t e;
        ID_VALID = v;  ID_RS = rs;  ID_RT = rt;  ID_USE_RS = urs;  ID_USE_RT = urt;
        ID_RD = rd;    ID_REGWRITE = rw;  ID_MEMREAD = mr;  FLUSH = fl;
        #1;
        chk({tag, ".stall"}, 32'(STALL), 32'(es));
        if (es && model_cnt != 32'hFFFF_FFFF) model_cnt = model_cnt + 32'd1;
        e.tag = tag;  e.fa = ea;  e.fb = eb;  e.bub = ebub;  e.cnt = model_cnt;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".fwd_a"},  32'(FWD_A),     32'(e.fa));
        chk({e.tag, ".fwd_b"},  32'(FWD_B),     32'(e.fb));
        chk({e.tag, ".bubble"}, 32'(EX_BUBBLE), 32'(e.bub));
        chk({e.tag, ".cnt"},    STALL_CNT,      e.cnt);
        @(negedge CLK);
    endtask

    initial begin
        logic [4:0] r;
        RESET = 1'b1;  ID_VALID = 1'b0;  ID_RS = '0;  ID_RT = '0;  ID_USE_RS = 1'b0;
        ID_USE_RT = 1'b0;  ID_RD = '0;  ID_REGWRITE = 1'b0;  ID_MEMREAD = 1'b0;  FLUSH = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst.fwd_a",  32'(FWD_A),     32'd0);
        chk("rst.fwd_b",  32'(FWD_B),     32'd0);
        chk("rst.bubble", 32'(EX_BUBBLE), 32'd1);
        chk("rst.cnt",    STALL_CNT,      32'd0);
        chk("rst.stall",  32'(STALL),     32'd0);
        RESET = 1'b0;

        //    tag          v  rs    rt    urs urt rd    rw mr fl  stall a  b  bub
        step("add_r3",     1, 5'd1, 5'd2, 1, 1, 5'd3,  1, 0, 0,  0, 0, 0, 0);
        step("sub_rs3",    1, 5'd3, 5'd4, 1, 1, 5'd5,  1, 0, 0,  0, 1, 0, 0);
        step("dist2_rt3",  1, 5'd9, 5'd3, 1, 1, 5'd11, 1, 0, 0,  0, 0, 2, 0);
        step("wr_r7_a",    1, 5'd1, 5'd2, 1, 1, 5'd7,  1, 0, 0,  0, 0, 0, 0);
        step("wr_r7_b",    1, 5'd7, 5'd0, 1, 0, 5'd7,  1, 0, 0,  0, 1, 0, 0);
        step("newest_r7",  1, 5'd7, 5'd7, 1, 0, 5'd12, 1, 0, 0,  0, 1, 0, 0);
        step("lw_r2",      1, 5'd0, 5'd0, 0, 0, 5'd2,  1, 1, 0,  0, 0, 0, 0);
        step("use_stall",  1, 5'd2, 5'd2, 1, 1, 5'd6,  1, 0, 0,  1, 0, 0, 1);
        step("use_retry",  1, 5'd2, 5'd2, 1, 1, 5'd6,  1, 0, 0,  0, 2, 2, 0);
        step("lw_r2_b",    1, 5'd0, 5'd0, 0, 0, 5'd2,  1, 1, 0,  0, 0, 0, 0);
        step("use_flush",  1, 5'd2, 5'd2, 1, 1, 5'd6,  1, 0, 1,  0, 0, 0, 1);
        step("lw_r0",      1, 5'd0, 5'd0, 0, 0, 5'd0,  1, 1, 0,  0, 0, 0, 0);
        step("use_r0",     1, 5'd0, 5'd0, 1, 1, 5'd13, 1, 0, 0,  0, 0, 0, 0);
        step("idle",       0, 5'd0, 5'd0, 0, 0, 5'd0,  0, 0, 0,  0, 0, 0, 1);

        // Accumulate six more load-use stalls so the counter reaches 7.
        for (int i = 0; i < 6; i++) begin
            r = 5'(20 + i);
            step("loop_lw",    1, 5'd0, 5'd0, 0, 0, r,     1, 1, 0,  0, 0, 0, 0);
            step("loop_stall", 1, r,    5'd1, 1, 1, 5'd30, 1, 0, 0,  1, 0, 0, 1);
            step("loop_retry", 1, r,    5'd1, 1, 1, 5'd30, 1, 0, 0,  0, 2, 0, 0);
        end
        step("lw_r25",     1, 5'd0, 5'd0, 0, 0, 5'd25, 1, 1, 0,  0, 0, 0, 0);

        // Pending hazard, then asynchronous reset between edges.
        ID_VALID = 1'b1;  ID_RS = 5'd25;  ID_RT = 5'd25;  ID_USE_RS = 1'b1;  ID_USE_RT = 1'b1;
        ID_RD = 5'd3;  ID_REGWRITE = 1'b1;  ID_MEMREAD = 1'b0;  FLUSH = 1'b0;
        #1;
        chk("pre_rst.stall", 32'(STALL),  32'd1);
        chk("pre_rst.cnt",   STALL_CNT,   32'd7);
        RESET = 1'b1;
        #1;
        chk("mid_rst.fwd_a",  32'(FWD_A),     32'd0);
        chk("mid_rst.fwd_b",  32'(FWD_B),     32'd0);
        chk("mid_rst.bubble", 32'(EX_BUBBLE), 32'd1);
        chk("mid_rst.cnt",    STALL_CNT,      32'd0);
        chk("mid_rst.stall",  32'(STALL),     32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        model_cnt = 0;
        step("post_rst",   1, 5'd25, 5'd25, 1, 1, 5'd3, 1, 0, 0,  0, 0, 0, 0);
        step("post_rst_2", 1, 5'd3,  5'd25, 1, 1, 5'd4, 1, 0, 0,  0, 1, 0, 0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
